// File: rtl/dreg_univ_shift.sv
// WIDTH-bit universal shift register: hold/load/shift/rotate/clear plus an
// autonomous LSB-first serialiser with busy/done status.
module dreg_univ_shift #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_LOAD  = 3'b001,
    M_SHL   = 3'b010,
    M_SHR   = 3'b011,
    M_ROL   = 3'b100,
    M_ROR   = 3'b101,
    M_CLEAR = 3'b110,
    M_SER   = 3'b111
  } mode_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;

  // Command acceptance: an operation is taken on an edge where en=1 and
  // busy=0; while busy=1 all command inputs (en, mode, d, sin) are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= RST_VAL;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          case (mode_t'(mode))
            M_HOLD:  q_nxt = q;
            M_LOAD:  q_nxt = d;
            M_SHL:   q_nxt = {q[WIDTH-2:0], sin};
            M_SHR:   q_nxt = {sin, q[WIDTH-1:1]};
            M_ROL:   q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:   q_nxt = {q[0], q[WIDTH-1:1]};
            M_CLEAR: q_nxt = '0;
            M_SER: begin
              q_nxt     = d;
              cnt_nxt   = '0;
              state_nxt = SHIFT;
            end
            default: q_nxt = q;
          endcase
        end
      end
      SHIFT: begin
        // The last bit is already on ser_out; hold it one more cycle, then finish.
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          q_nxt   = {1'b0, q[WIDTH-1:1]};
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ser_out = q[0];
  assign busy    = (state == SHIFT);

endmodule

// File: tb/tb_dreg_univ_shift.sv
// Self-checking bench for dreg_univ_shift: directed scenarios plus randomized
// traffic against a count-down behavioural model.
module tb_dreg_univ_shift;

  localparam int W = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk = 1'b0;
  logic         rst, en, sin;
  logic [2:0]   mode;
  logic [W-1:0] d, q;
  logic         ser_out, busy, done;

  int tests = 0;
  int fails = 0;

  // Behavioural model: value, remaining serialiser cycles, done flag.
  logic [W-1:0] m_q;
  int           m_rem;
  logic         m_done;

  dreg_univ_shift #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .sin(sin),
    .q(q), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Drive inputs, advance one rising edge (updating the model), return at negedge.
  task automatic cycle(input logic r, input logic e, input logic [2:0] m,
                       input logic [W-1:0] dd, input logic s);
    rst = r; en = e; mode = m; d = dd; sin = s;
    @(posedge clk);
    if (r) begin
      m_q = RV; m_rem = 0; m_done = 1'b0;
    end else if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      if (m_rem != 0) m_q = m_q >> 1;
    end else begin
      m_done = 1'b0;
      if (e) begin
        case (m)
          3'd1: m_q = dd;
          3'd2: m_q = (m_q << 1) | W'(s);
          3'd3: m_q = (m_q >> 1) | (W'(s) << (W - 1));
          3'd4: m_q = (m_q << 1) | (m_q >> (W - 1));
          3'd5: m_q = (m_q >> 1) | (m_q << (W - 1));
          3'd6: m_q = '0;
          3'd7: begin m_q = dd; m_rem = W; end
          default: ;
        endcase
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    cycle(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0);
    cycle(1'b1, 1'b1, 3'd1, 8'hFF, 1'b0);
    tests++;
    if (q !== RV) begin fails++; $display("FAIL reset_q got=%h exp=%h", q, RV); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_ops;
    logic [2:0]   modes [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd1};
    logic         sins  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] ds    [8] = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A};
    logic [W-1:0] exps  [8] = '{8'h81, 8'h03, 8'h81, 8'h03, 8'h81, 8'hC0, 8'h00, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, modes[i], ds[i], sins[i]);
      tests++;
      if (q !== exps[i]) begin
        fails++; $display("FAIL ops_step%0d mode=%0d got=%h exp=%h", i, modes[i], q, exps[i]);
      end
    end
    cycle(1'b0, 1'b0, 3'd1, 8'hFF, 1'b1);
    tests++;
    if (q !== 8'h5A) begin fails++; $display("FAIL en_low_hold got=%h exp=5a", q); end
  endtask

  // Serialise d; optionally drive a competing load during busy cycles.
  task automatic run_serialise(input logic [W-1:0] val, input logic disturb, input string tag);
    int busy_cnt;
    busy_cnt = 0;
    cycle(1'b0, 1'b1, 3'd7, val, 1'b0);
    for (int i = 0; i < W; i++) begin
      tests++;
      if (ser_out !== val[i] || busy !== 1'b1) begin
        fails++; $display("FAIL %s_bit%0d ser_out=%b busy=%b exp ser_out=%b busy=1", tag, i, ser_out, busy, val[i]);
      end
      if (busy === 1'b1) busy_cnt++;
      if (disturb) cycle(1'b0, 1'b1, 3'd1, 8'h00, 1'($urandom_range(0, 1)));
      else         cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b1 || busy_cnt != W) begin
      fails++; $display("FAIL %s_end busy=%b done=%b busy_cycles=%0d exp 0/1/%0d", tag, busy, done, busy_cnt, W);
    end
    tests++;
    if (q !== W'(val >> (W - 1))) begin
      fails++; $display("FAIL %s_final_q got=%h exp=%h", tag, q, W'(val >> (W - 1)));
    end
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse got=%b exp=0", tag, done); end
  endtask

  task automatic test_serialise;
    run_serialise(8'hB4, 1'b0, "ser");
  endtask

  task automatic test_busy_lockout;
    run_serialise(8'hB4, 1'b1, "lockout");
  endtask

  task automatic test_reset_mid;
    int done_seen;
    done_seen = 0;
    cycle(1'b0, 1'b1, 3'd7, 8'h6C, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy4 got=%b exp=1", busy); end
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    tests++;
    if (q !== RV || busy !== 1'b0) begin
      fails++; $display("FAIL rstmid_state q=%h busy=%b exp q=%h busy=0", q, busy, RV);
    end
    for (int i = 0; i < W + 4; i++) begin
      if (done === 1'b1) done_seen++;
      cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    tests++;
    if (done_seen != 0) begin fails++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", done_seen); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] vals [2] = '{8'h0F, 8'hF0};
    int pulses;
    pulses = 0;
    cycle(1'b0, 1'b1, 3'd7, vals[0], 1'b0);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < W; i++) begin
        tests++;
        if (ser_out !== vals[s][i] || busy !== 1'b1) begin
          fails++; $display("FAIL b2b_s%0d_bit%0d ser_out=%b busy=%b exp %b/1", s, i, ser_out, busy, vals[s][i]);
        end
        if (done === 1'b1) pulses++;
        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
      end
      tests++;
      if (done !== 1'b1) begin fails++; $display("FAIL b2b_s%0d_done got=%b exp=1", s, done); end
      if (done === 1'b1) pulses++;
      if (s == 0) cycle(1'b0, 1'b1, 3'd7, vals[1], 1'b0);
      else        cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    end
    if (done === 1'b1) pulses++;
    tests++;
    if (pulses != 2) begin fails++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  task automatic test_random;
    logic [2:0] m;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 5) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
      cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0), m,
            W'($urandom), 1'($urandom_range(0, 1)));
      tests++;
      if (q !== m_q || busy !== (m_rem > 0) || done !== m_done || ser_out !== m_q[0]) begin
        fails++;
        $display("FAIL random_c%0d q=%h busy=%b done=%b ser=%b exp q=%h busy=%b done=%b ser=%b",
                 i, q, busy, done, ser_out, m_q, (m_rem > 0), m_done, m_q[0]);
      end
    end
  endtask

  initial begin
    m_q = RV; m_rem = 0; m_done = 1'b0;
    test_reset;
    test_ops;
    test_serialise;
    test_busy_lockout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dreg_univ_shift.md
Name: dreg_univ_shift

Overview:
- Parametrised successor to the team's single-bit storage element: a WIDTH-bit clocked register with synchronous reset and a programmable reset value.
- Supports hold, parallel load, shift left/right, rotate left/right and clear.
- Adds an autonomous LSB-first serialiser mode, driven by a small FSM and counter, with busy/done status.
- Used wherever datapath staging, bit-serial output or simple shift-based sequencing is needed.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- RST_VAL, 0, value loaded into q on reset; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: synchronous, active-high.
- en  input  1  operation enable; when low, q holds (mode ignored) unless the serialiser is active.
- mode  input  3  operation select; sampled only when en=1 and busy=0.
- d  input  WIDTH  parallel load / serialiser source data.
- sin  input  1  serial input for shift modes.
- q  output  WIDTH  register contents.
- ser_out  output  1  always equal to q[0] (combinational from q).
- busy  output  1  high while the serialiser FSM is in SHIFT.
- done  output  1  one-cycle pulse when serialisation completes.

Behaviour:
- All state updates on the rising edge of clk; no latches, no async paths.
- Reset (rst=1 at an edge) has priority over everything, including a serialisation in progress: q<=RST_VAL, busy<=0, done<=0, counter<=0, FSM<=IDLE. The aborted serialisation produces no done pulse.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- In IDLE with en=0: q holds; done<=0.
- In IDLE with en=1, the next q is set by mode:
  - 000 hold: q unchanged.
  - 001 load: q<=d.
  - 010 shift left: q<={q[WIDTH-2:0], sin}.
  - 011 shift right: q<={sin, q[WIDTH-1:1]}.
  - 100 rotate left: q<={q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 rotate right: q<={q[0], q[WIDTH-1:1]}.
  - 110 clear: q<=0 (zero, not RST_VAL).
  - 111 serialise start: q<=d, counter<=0, FSM->SHIFT.
- SHIFT state, one step per edge; en, mode, d and sin are ignored:
  - If counter < WIDTH-1: q<={1'b0, q[WIDTH-1:1]}, counter<=counter+1.
  - If counter == WIDTH-1: q holds, FSM->IDLE, done<=1 for exactly one cycle.
- Serialise timing:
  - ser_out presents d[0], d[1], ..., d[WIDTH-1] on WIDTH consecutive cycles, starting the cycle after the start edge.
  - busy is high for exactly those WIDTH cycles.
  - done is high in the first cycle after busy falls.
  - After completion q = d>>(WIDTH-1), i.e. {0...0, d[WIDTH-1]}.
- done is cleared on every edge except the completing edge. A new operation (including mode 111) is accepted in the same cycle done is high, so back-to-back serialisations give a continuous ser_out stream with one gap cycle.
- Counter width is $clog2(WIDTH); it never exceeds WIDTH-1 and is never wrapped.
- Width rules: all shifts are WIDTH-bit logical; no sign extension; sin is used only in modes 010/011.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5; hold rst=1 for 2 edges with en=1, mode=001, d=8'hFF -> q=8'hA5, busy=0, done=0; rst wins over load.
- Load/shift/rotate, WIDTH=8: load 8'h81, then the following sequence with the results shown:
  - shift left, sin=1 -> 8'h03
  - shift right, sin=1 -> 8'h81
  - rotate left -> 8'h03
  - rotate right twice -> 8'hC0
  - clear -> 8'h00
  - en=0 with mode=001 -> q unchanged.
- Serialise: d=8'hB4, mode=111 for one cycle -> ser_out over the next 8 cycles = 0,0,1,0,1,1,0,1; busy=1 for exactly 8 cycles; done=1 on cycle 9 only; final q=8'h01.
- Busy lockout: during serialisation drive en=1, mode=001, d=8'h00 -> ser_out sequence unchanged; no load occurs.
- Reset mid-serialise: assert rst on the 4th busy cycle -> next cycle q=RST_VAL, busy=0, and done never asserts.
- Back-to-back: start 8'h0F, then start 8'hF0 in the cycle done=1 -> second stream 0,0,0,0,1,1,1,1 begins the next cycle; done pulses once per stream.
